// File: rtl/game_state_ctrl.sv
// Game-flow controller: sequences START -> GAME -> PLAYER_x -> START and
// commits every screen change on a vblank rising edge so the display never
// switches mid-frame. Also pulses game_rst on GAME entry and keeps scores.
module game_state_ctrl #(
    parameter int RESULT_FRAMES = 300,
    parameter int MIN_HOLD      = 60,
    parameter int SCORE_MAX     = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       vblnk,
    output logic [1:0] screen,
    output logic       game_rst,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);

    localparam int CNT_W = $clog2(RESULT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RESULT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       SCORE_TOP = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } state_t;

    state_t           state_q;
    state_t           req_state;
    logic             req_vld;
    logic [CNT_W-1:0] frame_cnt;
    logic             game_enter;

    logic btn_s1, btn_s2, btn_s3;
    logic start_pulse;
    logic vblnk_q;
    logic frame_tick;

    assign screen     = state_q;
    assign frame_tick = vblnk & ~vblnk_q;

    // Synchronize the raw button, register its rising edge, and delay vblank for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            btn_s3      <= 1'b0;
            start_pulse <= 1'b0;
            vblnk_q     <= 1'b0;
        end else begin
            btn_s1      <= btn_start;
            btn_s2      <= btn_s1;
            btn_s3      <= btn_s2;
            start_pulse <= btn_s2 & ~btn_s3;
            vblnk_q     <= vblnk;
        end
    end

    // Screen FSM: latch one pending request, commit it on the next frame tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= START;
            req_state  <= START;
            req_vld    <= 1'b0;
            frame_cnt  <= '0;
            game_enter <= 1'b0;
            game_rst   <= 1'b0;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
        end else begin
            game_enter <= 1'b0;
            game_rst   <= game_enter;
            if (frame_tick && req_vld) begin
                // Commit cycle: new requests seen now are against the old screen, so drop them.
                req_vld   <= 1'b0;
                frame_cnt <= '0;
                case (state_q)
                    START, GAME, PLAYER_1, PLAYER_2: begin
                        state_q <= req_state;
                        if (req_state == GAME) begin
                            game_enter <= 1'b1;
                        end
                        if (req_state == PLAYER_1 && p1_score < SCORE_TOP) begin
                            p1_score <= p1_score + 4'd1;
                        end
                        if (req_state == PLAYER_2 && p2_score < SCORE_TOP) begin
                            p2_score <= p2_score + 4'd1;
                        end
                    end
                    default: state_q <= START;
                endcase
            end else begin
                case (state_q)
                    START: begin
                        frame_cnt <= '0;
                        if (start_pulse && !req_vld) begin
                            req_state <= GAME;
                            req_vld   <= 1'b1;
                        end
                    end
                    GAME: begin
                        frame_cnt <= '0;
                        if (!req_vld) begin
                            if (p1_win) begin
                                req_state <= PLAYER_1;
                                req_vld   <= 1'b1;
                            end else if (p2_win) begin
                                req_state <= PLAYER_2;
                                req_vld   <= 1'b1;
                            end
                        end
                    end
                    PLAYER_1, PLAYER_2: begin
                        if (frame_tick && frame_cnt != CNT_MAX) begin
                            frame_cnt <= frame_cnt + CNT_ONE;
                        end
                        // Early button press before the minimum hold is simply not remembered.
                        if (!req_vld && (frame_cnt == CNT_MAX ||
                                         (start_pulse && frame_cnt >= CNT_HOLD))) begin
                            req_state <= START;
                            req_vld   <= 1'b1;
                        end
                    end
                    default: begin
                        // Unknown encoding: recover to START on the next frame tick.
                        req_vld <= 1'b0;
                        if (frame_tick) begin
                            state_q   <= START;
                            frame_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: screen sequencing, frame-aligned
// commits, result hold timing, score saturation and async reset.
module tb_game_state_ctrl;

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_GAME  = 2'd1;
    localparam logic [1:0] S_P1    = 2'd2;
    localparam logic [1:0] S_P2    = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       p1_win = 1'b0;
    logic       p2_win = 1'b0;
    logic       vblnk = 1'b0;
    logic [1:0] screen;
    logic       game_rst;
    logic [3:0] p1_score;
    logic [3:0] p2_score;

    int errors = 0;
    int checks = 0;

    game_state_ctrl #(
        .RESULT_FRAMES(300),
        .MIN_HOLD(60),
        .SCORE_MAX(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .p1_win(p1_win),
        .p2_win(p2_win),
        .vblnk(vblnk),
        .screen(screen),
        .game_rst(game_rst),
        .p1_score(p1_score),
        .p2_score(p2_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: vblnk high for hi cycles then low for 4.
    task automatic frame(input int hi = 2);
        vblnk = 1'b1;
        cyc(hi);
        vblnk = 1'b0;
        cyc(4);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        btn_start = 1'b1;
        cyc(5);
        btn_start = 1'b0;
        cyc(3);
    endtask

    task automatic win(input logic a, input logic b);
        p1_win = a;
        p2_win = b;
        cyc(1);
        p1_win = 1'b0;
        p2_win = 1'b0;
        cyc(1);
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("rst_screen", screen, S_START);
        check("rst_game_rst", game_rst, 0);
        check("rst_p1", p1_score, 0);
        check("rst_p2", p2_score, 0);
        rst = 1'b1;
        cyc(2);

        // Button alone never changes screen without a frame tick
        press();
        cyc(10);
        check("start_no_tick", screen, S_START);

        // Commit to GAME on the tick, game_rst one cycle after commit
        vblnk = 1'b1;
        cyc(1);
        check("game_commit", screen, S_GAME);
        check("game_rst_lag", game_rst, 0);
        cyc(1);
        check("game_rst_hi", game_rst, 1);
        vblnk = 1'b0;
        cyc(1);
        check("game_rst_lo", game_rst, 0);
        cyc(3);

        // Simultaneous wins: player 1 has priority
        win(1'b1, 1'b1);
        cyc(3);
        check("win_no_tick", screen, S_GAME);
        frame();
        check("p1_commit", screen, S_P1);
        check("p1_score_1", p1_score, 1);
        check("p2_score_0", p2_score, 0);

        // Early press (frame 10) dropped; press at frame 70 returns to START
        frames(10);
        press();
        frame();
        check("early_btn_ignored", screen, S_P1);
        frames(59);
        press();
        check("late_btn_wait_tick", screen, S_P1);
        frame();
        check("late_btn_start", screen, S_START);

        // First win latched, later win ignored
        press();
        frame();
        check("game_again", screen, S_GAME);
        win(1'b0, 1'b1);
        win(1'b1, 1'b0);
        frame();
        check("p2_first_win", screen, S_P2);
        check("p2_score_1", p2_score, 1);
        check("p1_score_kept", p1_score, 1);

        // Auto-return after 300 ticks; one long vblank counts once
        frame(40);
        frames(298);
        check("p2_hold_299", screen, S_P2);
        frame();
        check("p2_hold_300", screen, S_P2);
        frame();
        check("p2_auto_start", screen, S_START);

        // Score saturation over repeated P1 wins
        for (int i = 0; i < 9; i++) begin
            press();
            frame();
            win(1'b1, 1'b0);
            frame();
            check("sat_p1_screen", screen, S_P1);
            check("sat_p1_score", p1_score, (i + 2 > 9) ? 9 : i + 2);
            frames(60);
            press();
            frame();
            check("sat_return", screen, S_START);
        end
        check("p2_score_still_1", p2_score, 1);

        // Async reset mid-GAME with request pending
        press();
        frame();
        check("pre_rst_game", screen, S_GAME);
        win(1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_screen", screen, S_START);
        check("arst_p1", p1_score, 0);
        check("arst_p2", p2_score, 0);
        check("arst_game_rst", game_rst, 0);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        frame();
        check("arst_req_cleared", screen, S_START);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
